// File: rtl/four_to_two_encoder_pkg.sv
// ---------------------------------------------------------------------------
// four_to_two_encoder_pkg
//   Shared definitions for the sequential 4-to-2 priority encoder:
//   - state_t        : presenter FSM states (ST_IDLE, ST_PRESENT)
//   - N_DEFAULT      : default number of request lines
//   - W_DEFAULT      : code width rule, $clog2(N_DEFAULT)
//   - SYNC_RESET_VAL : reset value of synchronizer/prev flops (all ones,
//                      i.e. every active-low line inactive). Slice to width.
//   - highest_set()  : index of the highest set bit (0 when none set)
// ---------------------------------------------------------------------------
package four_to_two_encoder_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = $clog2(N_DEFAULT);

  // Wide enough for any N up to 64; users slice [N-1:0].
  localparam logic [63:0] SYNC_RESET_VAL = '1;

  // Highest set index of a request vector. Ascending scan, so the last
  // hit (the highest index) wins. Callers zero-extend their vector to 32.
  function automatic int highest_set(input logic [31:0] vec);
    highest_set = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) highest_set = i;
    end
  endfunction

endpackage : four_to_two_encoder_pkg

// File: rtl/four_to_two_encoder_if.sv
// ---------------------------------------------------------------------------
// four_to_two_encoder_if
//   Bundles the request lines, enable, and the code valid/ready channel.
//   Ports (signals):
//     req_n    [N-1:0] active-low request lines (asynchronous to clk)
//     en_n             active-low enable for launching a new code
//     code     [W-1:0] binary index being presented
//     valid            code is valid
//     ready            consumer accepts code when valid && ready
//     pending  [N-1:0] latched, not-yet-served requests
//     overflow         one-cycle pulse when a request edge is lost
//   Modports:
//     master : the encoder (drives code/valid/pending/overflow)
//     slave  : the request source + consumer
// ---------------------------------------------------------------------------
interface four_to_two_encoder_if #(
  parameter int N = four_to_two_encoder_pkg::N_DEFAULT,
  parameter int W = four_to_two_encoder_pkg::W_DEFAULT
);

  logic [N-1:0] req_n;
  logic         en_n;
  logic [W-1:0] code;
  logic         valid;
  logic         ready;
  logic [N-1:0] pending;
  logic         overflow;

  modport master (
    input  req_n,
    input  en_n,
    input  ready,
    output code,
    output valid,
    output pending,
    output overflow
  );

  modport slave (
    output req_n,
    output en_n,
    output ready,
    input  code,
    input  valid,
    input  pending,
    input  overflow
  );

endinterface : four_to_two_encoder_if

// File: rtl/four_to_two_encoder_req_sync_edge.sv
// ---------------------------------------------------------------------------
// req_sync_edge
//   N-bit multi-flop synchronizer followed by a falling-edge detector.
//   Ports:
//     clk               rising-edge clock
//     rst               asynchronous active-high reset
//     req_n   [N-1:0]   asynchronous active-low request lines
//     events  [N-1:0]   one-cycle high per synchronized falling edge
//   A line held low produces exactly one event.
// ---------------------------------------------------------------------------
module req_sync_edge
  import four_to_two_encoder_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_n,
  output logic [N-1:0] events
);

  logic [N-1:0] stage_q [SYNC_STAGES];
  logic [N-1:0] prev_q;

  // NOTE: every flop of the chain is reset, not just the last one; a stale
  // low in an early stage would otherwise emerge as a false edge after reset.
  // NOTE: sequential state uses non-blocking assignments so each stage picks
  // up its neighbour's pre-edge value, giving a true shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage_q[s] <= SYNC_RESET_VAL[N-1:0];
      end
      prev_q <= SYNC_RESET_VAL[N-1:0];
    end else begin
      stage_q[0] <= req_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  // Falling edge: currently low, previously high.
  assign events = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule : req_sync_edge

// File: rtl/four_to_two_encoder.sv
// ---------------------------------------------------------------------------
// four_to_two_encoder
//   Sequential priority encoder. Falling edges on active-low request lines
//   are latched as pending events and presented one at a time, highest
//   index first, as a binary code on a valid/ready channel.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   four_to_two_encoder_if.master (req_n, en_n, ready in;
//           code, valid, pending, overflow out)
//   Parameters:
//     N           number of request lines
//     W           code width, must equal $clog2(N)
//     SYNC_STAGES synchronizer depth on req_n (>= 2)
// ---------------------------------------------------------------------------
module four_to_two_encoder
  import four_to_two_encoder_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int W           = $clog2(N),
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  four_to_two_encoder_if.master bus
);

  state_t       state_q, state_d;
  logic [W-1:0] code_q;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;
  logic [N-1:0] events;
  logic [N-1:0] clr;
  logic         handshake;

  req_sync_edge #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .req_n  (bus.req_n),
    .events (events)
  );

  // valid is a pure decode of the state register, so it is glitch-free.
  assign handshake = (state_q == ST_PRESENT) && bus.ready;

  // Pending bookkeeping. A new event on the bit being served wins over the
  // clear, so that event is not lost and is not counted as overflow.
  // NOTE: all always_comb outputs get a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    clr = '0;
    if (handshake) clr[code_q] = 1'b1;
    pending_d  = (pending_q & ~clr) | events;
    overflow_d = |(events & pending_q & ~clr);
  end

  // FSM process 1: state register plus the registers it qualifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      // code only moves on IDLE->PRESENT; priority is not re-evaluated
      // while a code is outstanding.
      if (state_q == ST_IDLE && state_d == ST_PRESENT) begin
        code_q <= W'(highest_set(32'(pending_q)));
      end
    end
  end

  // FSM process 2: next state. en_n only gates a launch; once presenting,
  // the code completes regardless of en_n.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (!bus.en_n && (|pending_q)) state_d = ST_PRESENT;
      ST_PRESENT: if (bus.ready)                 state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM process 3: outputs.
  always_comb begin
    bus.valid    = (state_q == ST_PRESENT);
    bus.code     = code_q;
    bus.pending  = pending_q;
    bus.overflow = overflow_q;
  end

endmodule : four_to_two_encoder
